// File: rtl/piece_mover.sv
// rtl/piece_mover.sv - falling piece position, gravity timer, edge-clamped moves and respawn
// Optional held-key auto-repeat is built when PIECE_MOVER_AUTO_REPEAT_EN is defined.
module piece_mover #(
  parameter int COLS       = 8,
  parameter int ROWS       = 8,
  parameter int FALL_DIV   = 12_500_000,
  parameter int REPEAT_DIV = 3_125_000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    right,
  input  logic                    left,
  input  logic                    start,
  output logic [$clog2(ROWS)-1:0] row,
  output logic [$clog2(COLS)-1:0] col,
  output logic                    active,
  output logic                    moved,
  output logic                    landed
);
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam int FW = $clog2(FALL_DIV);
  localparam logic [CW-1:0] SPAWN     = CW'(COLS / 2);
  localparam logic [CW-1:0] COL_MAX   = CW'(COLS - 1);
  localparam logic [RW-1:0] ROW_MAX   = RW'(ROWS - 1);
  localparam logic [FW-1:0] FALL_LAST = FW'(FALL_DIV - 1);

  if (FALL_DIV < 2 || REPEAT_DIV < 2) begin : g_bad_div
    $error("piece_mover: FALL_DIV and REPEAT_DIV must be >= 2");
  end

  typedef enum logic [1:0] {S_IDLE, S_FALL, S_LAND} state_t;

  state_t        r_state, w_state_nxt;
  logic [RW-1:0] r_row, w_row_nxt;
  logic [CW-1:0] r_col, w_col_nxt;
  logic [FW-1:0] r_fall_cnt, w_fall_cnt_nxt;
  logic          r_moved, w_moved_nxt;
  logic          r_landed, w_landed_nxt;
  logic          r_right_q, r_left_q;
  logic          w_tick, w_edge_right, w_edge_left, w_go_right, w_go_left;

  assign w_tick       = (r_state == S_FALL) && (r_fall_cnt == FALL_LAST);
  // An edge only counts as a move when the other direction is not also high.
  assign w_edge_right = right & ~r_right_q & ~left;
  assign w_edge_left  = left & ~r_left_q & ~right;

`ifdef PIECE_MOVER_AUTO_REPEAT_EN
  localparam int PW = $clog2(REPEAT_DIV);
  logic [PW-1:0] r_rep_cnt, w_rep_cnt_nxt;
  logic          w_rep_fire;

  always_comb begin
    w_rep_cnt_nxt = '0;
    w_rep_fire    = 1'b0;
    if (r_state == S_FALL && (right ^ left) && !(w_edge_right || w_edge_left)) begin
      if (r_rep_cnt == PW'(REPEAT_DIV - 1)) w_rep_fire = 1'b1;
      else                                  w_rep_cnt_nxt = r_rep_cnt + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rep_cnt <= '0;
    else        r_rep_cnt <= w_rep_cnt_nxt;
  end

  assign w_go_right = w_edge_right | (w_rep_fire & right);
  assign w_go_left  = w_edge_left | (w_rep_fire & left);
`else
  assign w_go_right = w_edge_right;
  assign w_go_left  = w_edge_left;
`endif

  always_comb begin
    w_state_nxt    = r_state;
    w_row_nxt      = r_row;
    w_col_nxt      = r_col;
    w_fall_cnt_nxt = '0;
    w_moved_nxt    = 1'b0;
    w_landed_nxt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_FALL;
          w_row_nxt   = '0;
          w_col_nxt   = SPAWN;
        end
      end
      S_FALL: begin
        w_fall_cnt_nxt = w_tick ? '0 : r_fall_cnt + FW'(1);
        if (w_go_right && r_col != COL_MAX) begin
          w_col_nxt   = r_col + CW'(1);
          w_moved_nxt = 1'b1;
        end else if (w_go_left && r_col != '0) begin
          w_col_nxt   = r_col - CW'(1);
          w_moved_nxt = 1'b1;
        end
        if (w_tick) begin
          if (r_row == ROW_MAX) begin
            w_state_nxt  = S_LAND;
            w_landed_nxt = 1'b1;
          end else begin
            w_row_nxt = r_row + RW'(1);
          end
        end
      end
      S_LAND: begin
        w_state_nxt = S_FALL;
        w_row_nxt   = '0;
        w_col_nxt   = SPAWN;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_row      <= '0;
      r_col      <= SPAWN;
      r_fall_cnt <= '0;
      r_moved    <= 1'b0;
      r_landed   <= 1'b0;
      r_right_q  <= 1'b0;
      r_left_q   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_row      <= w_row_nxt;
      r_col      <= w_col_nxt;
      r_fall_cnt <= w_fall_cnt_nxt;
      r_moved    <= w_moved_nxt;
      r_landed   <= w_landed_nxt;
      r_right_q  <= right;
      r_left_q   <= left;
    end
  end

  assign row    = r_row;
  assign col    = r_col;
  assign active = (r_state != S_IDLE);
  assign moved  = r_moved;
  assign landed = r_landed;
endmodule
